sram_rw_ctrl: RTL and testbench
===============================

# sram_rw_ctrl

Registered bus engine that turns single read/write commands from the RAM test control FSM into timed chip-select, output-enable and write-enable waveforms on the external asynchronous SRAM (BaseRAM). It sits directly downstream of the write/read control FSM. The FSM issues one command per state; this block executes it with fixed setup/strobe/hold phases and returns read data plus a completion pulse.

## Interface

Parameters:
- ADDR_W, 20, SRAM word address width
- DATA_W, 32, SRAM data width (must be multiple of 8)
- WAIT_CYC, 2, strobe (oe_n/we_n low) length in clk cycles; legal range 1..15

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request from control FSM
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  word address
- cmd_wdata  in  DATA_W  write data
- cmd_be  in  DATA_W/8  active-high byte enables (writes only)
- cmd_ready  out  1  command accepted on clk edge when cmd_valid & cmd_ready
- rsp_valid  out  1  one-cycle completion pulse (reads and writes)
- rsp_we  out  1  type of completed command
- rsp_rdata  out  DATA_W  read data, held until next read completes
- sram_addr  out  ADDR_W  SRAM address
- sram_dq_o  out  DATA_W  write data to pad
- sram_dq_oe  out  1  pad tri-state enable (1 = block drives bus)
- sram_dq_i  in  DATA_W  data from pad
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes
- sram_be_n  out  DATA_W/8  active-low byte enables

## Operation

- States: IDLE, SETUP, ACCESS, HOLD. Encoding free; illegal state returns to IDLE with all strobes inactive.
- IDLE: cmd_ready = 1 (combinational on state, forced 0 while rst high). On cmd_valid: latch cmd_we/addr/wdata/be, go SETUP. Otherwise stay.
- SETUP (1 cycle): ce_n = 0, sram_addr = latched address, sram_be_n = ~be for writes, all 0 for reads; dq_oe = we; oe_n = we_n = 1. Go ACCESS, wait counter loaded with WAIT_CYC-1.
- ACCESS (WAIT_CYC cycles): write asserts we_n = 0; read asserts oe_n = 0, dq_oe stays 0. Counter decrements; at 0 go HOLD. On the ACCESS->HOLD edge a read captures sram_dq_i into rsp_rdata.
- HOLD (1 cycle): oe_n = we_n = 1, ce_n = 0, address/data/dq_oe unchanged (write data hold). rsp_valid = 1, rsp_we = latched we. Go IDLE.
- On return to IDLE: ce_n = 1, dq_oe = 0; sram_addr and sram_dq_o keep last values.
- All sram_* outputs and rsp_* outputs are flop outputs (no combinational path to pads). cmd_ready is the only combinational output.
- cmd_valid while not IDLE is ignored, with no queueing. Command fields are sampled only on the accept edge.
- we_n and oe_n are never low in the same cycle. dq_oe = 1 only in SETUP/ACCESS/HOLD of a write.

## Timing

- Reset values (asynchronous, immediate): state IDLE; ce_n = oe_n = we_n = 1; sram_be_n all 1; dq_oe = 0; sram_addr = 0; sram_dq_o = 0; rsp_valid = 0; rsp_we = 0; rsp_rdata = 0.
- Accept at edge E0: SETUP during cycle after E0; ACCESS for WAIT_CYC cycles; HOLD next, with rsp_valid high. Total occupancy WAIT_CYC+3 cycles from accept edge to next possible accept.
- Back-to-back: cmd_valid held high during HOLD is accepted on the first IDLE cycle. Throughput is one command per WAIT_CYC+3 cycles.
- Read data: value on sram_dq_i in the last ACCESS cycle is the one captured. rsp_rdata is valid from the rsp_valid cycle onward.
- Reset mid-operation: strobes deassert and dq_oe drops the same cycle. No rsp_valid for the aborted command. Block is in IDLE with cmd_ready = 1 on the first cycle after rst falls.
- WAIT_CYC = 1: ACCESS lasts exactly one cycle; counter logic must not underflow.

## Test plan

- Reset: hold rst, toggle clk and cmd_valid -> ce_n/oe_n/we_n = 1, be_n = 1111, dq_oe = 0, cmd_ready = 0, no accept. Release -> cmd_ready = 1.
- Single write, WAIT_CYC = 2: addr 0x00012, data 0xDEADBEEF, be 1111 -> exactly 1 SETUP, 2 we_n-low cycles, 1 HOLD with rsp_valid = 1 and rsp_we = 1; dq_oe high for 4 cycles; bus model stores 0xDEADBEEF.
- Read back of same address via SRAM model -> oe_n low 2 cycles, dq_oe = 0 throughout, rsp_rdata = 0xDEADBEEF at rsp_valid.
- Byte write be = 0010 over 0xFFFFFFFF with data 0x0000AB00 -> be_n = 1101, readback 0xFFFFABFF.
- cmd_valid held high continuously, alternating write/read of 0x5A5A5A5A at 0xFFFFF -> accepts exactly every 5 cycles (WAIT_CYC = 2); no we_n/oe_n overlap; reads return 0x5A5A5A5A.
- rst pulsed during a write's ACCESS cycle -> we_n rises and dq_oe drops without waiting for clk; no rsp_valid; next command completes normally.

Source files
------------

// File: rtl/sram_rw_ctrl_if.sv
// Command/response and SRAM pad bundle for the SRAM bus engine.
// slave = engine, master = control FSM side, pad = external SRAM side.
interface sram_rw_ctrl_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              cmd_valid;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [BE_W-1:0]   cmd_be;
    logic              cmd_ready;

    logic              rsp_valid;
    logic              rsp_we;
    logic [DATA_W-1:0] rsp_rdata;

    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dq_o;
    logic              sram_dq_oe;
    logic [DATA_W-1:0] sram_dq_i;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic [BE_W-1:0]   sram_be_n;

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_be, sram_dq_i,
        output cmd_ready, rsp_valid, rsp_we, rsp_rdata,
               sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
    );

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_be,
        input  cmd_ready, rsp_valid, rsp_we, rsp_rdata
    );

    modport pad (
        input  sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n,
        output sram_dq_i
    );
endinterface

// File: rtl/sram_rw_ctrl.sv
// Single-command async SRAM engine: SETUP / strobe (WAIT_CYC) / HOLD phases,
// all pad and response outputs registered.
module sram_rw_ctrl #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 2
) (
    input  logic          clk,
    input  logic          rst,
    sram_rw_ctrl_if.slave bus
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_HOLD} state_t;

    state_t            r_state;
    logic              r_we;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dq_o;
    logic [DATA_W-1:0] r_rdata;
    logic [BE_W-1:0]   r_be_n;
    logic              r_ce_n;
    logic              r_oe_n;
    logic              r_we_n;
    logic              r_dq_oe;
    logic              r_rsp_valid;
    logic              r_rsp_we;
    logic              w_idle;

    assign w_idle = (r_state == ST_IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_dq_o      <= '0;
            r_rdata     <= '0;
            r_be_n      <= '1;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_dq_oe     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_we    <= bus.cmd_we;
                        r_addr  <= bus.cmd_addr;
                        r_dq_o  <= bus.cmd_wdata;
                        r_be_n  <= bus.cmd_we ? ~bus.cmd_be : '0;
                        r_ce_n  <= 1'b0;
                        r_dq_oe <= bus.cmd_we;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_cnt   <= 4'(WAIT_CYC - 1);
                    r_we_n  <= !r_we;
                    r_oe_n  <= r_we;
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // Counter is tested before decrementing, so WAIT_CYC=1 never wraps.
                    if (r_cnt == 4'd0) begin
                        r_we_n      <= 1'b1;
                        r_oe_n      <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_we    <= r_we;
                        if (!r_we) r_rdata <= bus.sram_dq_i;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_HOLD: begin
                    r_ce_n  <= 1'b1;
                    r_dq_oe <= 1'b0;
                    r_be_n  <= '1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ce_n  <= 1'b1;
                    r_oe_n  <= 1'b1;
                    r_we_n  <= 1'b1;
                    r_be_n  <= '1;
                    r_dq_oe <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = w_idle;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_we     = r_rsp_we;
    assign bus.rsp_rdata  = r_rdata;
    assign bus.sram_addr  = r_addr;
    assign bus.sram_dq_o  = r_dq_o;
    assign bus.sram_dq_oe = r_dq_oe;
    assign bus.sram_ce_n  = r_ce_n;
    assign bus.sram_oe_n  = r_oe_n;
    assign bus.sram_we_n  = r_we_n;
    assign bus.sram_be_n  = r_be_n;
endmodule

// File: tb/tb_sram_rw_ctrl.sv
// Randomized bench for sram_rw_ctrl: behavioural SRAM on the pads plus a
// command-level memory model that predicts read data and phase counts.
module tb_sram_rw_ctrl;
    localparam int AW = 20;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int WC = 2;
    localparam logic [DW-1:0] JUNK = 32'h0BAD_F00D;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_rw_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    sram_rw_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(WC)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] sram_mem [logic [AW-1:0]];
    logic [DW-1:0] ref_mem  [logic [AW-1:0]];
    logic [DW-1:0] last_rd = '0;
    int oe_cyc = 0;

    // Pad SRAM: data is only valid from the second cycle of oe_n low.
    always @(posedge clk) oe_cyc <= (!bus.sram_ce_n && !bus.sram_oe_n) ? oe_cyc + 1 : 0;
    always @(bus.sram_ce_n, bus.sram_oe_n, bus.sram_addr, oe_cyc) begin
        if (!bus.sram_ce_n && !bus.sram_oe_n && oe_cyc >= 1)
            bus.sram_dq_i = sram_mem.exists(bus.sram_addr) ? sram_mem[bus.sram_addr] : JUNK;
        else
            bus.sram_dq_i = JUNK;
    end
    always @(posedge clk) begin
        if (rst === 1'b0 && !bus.sram_ce_n && !bus.sram_we_n && bus.sram_dq_oe) begin
            logic [DW-1:0] v;
            v = sram_mem.exists(bus.sram_addr) ? sram_mem[bus.sram_addr] : '0;
            for (int b = 0; b < BW; b++)
                if (!bus.sram_be_n[b]) v[8*b +: 8] = bus.sram_dq_o[8*b +: 8];
            sram_mem[bus.sram_addr] = v;
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            if ((!bus.sram_we_n && !bus.sram_oe_n) || (bus.sram_dq_oe && !bus.sram_oe_n)) begin
                errors++;
                $display("FAIL strobe_conflict: we_n=%b oe_n=%b dq_oe=%b want no overlap",
                         bus.sram_we_n, bus.sram_oe_n, bus.sram_dq_oe);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Command-level model: returns the read data a command must produce.
    function automatic logic [DW-1:0] model_cmd(input logic we, input logic [AW-1:0] a,
                                                input logic [DW-1:0] d, input logic [BW-1:0] be);
        logic [DW-1:0] v;
        v = ref_mem.exists(a) ? ref_mem[a] : JUNK;
        if (we) begin
            for (int b = 0; b < BW; b++) if (be[b]) v[8*b +: 8] = d[8*b +: 8];
            ref_mem[a] = v;
            return last_rd;
        end
        last_rd = v;
        return v;
    endfunction

    task automatic run_cmd(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [BW-1:0] be,
                           output int n_ce, output int n_we, output int n_oe, output int n_dq,
                           output int rsp_at, output logic r_we, output logic [DW-1:0] rdata,
                           output logic [BW-1:0] ben, output logic rdy_end, output bit tmo);
        int w;
        n_ce = 0; n_we = 0; n_oe = 0; n_dq = 0; rsp_at = 0;
        r_we = 1'bx; rdata = 'x; ben = 'x; rdy_end = 1'b0; tmo = 1'b0;
        @(negedge clk);
        bus.cmd_we = we; bus.cmd_addr = a; bus.cmd_wdata = d; bus.cmd_be = be;
        bus.cmd_valid = 1'b1;
        w = 0;
        while (!bus.cmd_ready && w < 20) begin @(negedge clk); w++; end
        if (!bus.cmd_ready) begin tmo = 1'b1; bus.cmd_valid = 1'b0; return; end
        @(posedge clk);
        for (int k = 1; k <= WC + 3; k++) begin
            @(negedge clk);
            if (!bus.sram_ce_n) begin n_ce++; ben = bus.sram_be_n; end
            if (!bus.sram_we_n) n_we++;
            if (!bus.sram_oe_n) n_oe++;
            if (bus.sram_dq_oe) n_dq++;
            if (bus.rsp_valid) begin rsp_at = k; r_we = bus.rsp_we; rdata = bus.rsp_rdata; end
            if (k == WC + 3) rdy_end = bus.cmd_ready;
            if (k == 1) begin
                bus.cmd_valid = 1'b0;
                bus.cmd_we = 1'($urandom); bus.cmd_addr = AW'($urandom);
                bus.cmd_wdata = $urandom; bus.cmd_be = BW'($urandom);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.cmd_valid = 1'($urandom); bus.cmd_we = 1'($urandom);
            bus.cmd_addr = AW'($urandom); bus.cmd_wdata = $urandom; bus.cmd_be = BW'($urandom);
            #1;
            checks++;
            if ({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_be_n, bus.sram_dq_oe,
                 bus.cmd_ready, bus.rsp_valid, bus.rsp_we} !== {3'b111, 4'b1111, 4'b0000}) begin
                errors++;
                $display("FAIL reset_ctrl: ce/oe/we/be_n/dq_oe/rdy/rv/rwe=%b want 1111111 0000",
                         {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_be_n, bus.sram_dq_oe,
                          bus.cmd_ready, bus.rsp_valid, bus.rsp_we});
            end
            checks++;
            if ({bus.sram_addr, bus.sram_dq_o, bus.rsp_rdata} !== '0) begin
                errors++;
                $display("FAIL reset_data: addr=%h dq_o=%h rdata=%h want 0", bus.sram_addr,
                         bus.sram_dq_o, bus.rsp_rdata);
            end
        end
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b want 1", bus.cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.sram_ce_n !== 1'b1) begin
            errors++; $display("FAIL reset_no_accept: ce_n=%b want 1", bus.sram_ce_n);
        end
    endtask

    task automatic test_single_write;
        int n_ce, n_we, n_oe, n_dq, at; logic rwe, rdy; logic [DW-1:0] rd, exp_rd; logic [BW-1:0] ben; bit tmo;
        exp_rd = model_cmd(1'b1, 20'h00012, 32'hDEADBEEF, 4'hF);
        run_cmd(1'b1, 20'h00012, 32'hDEADBEEF, 4'hF, n_ce, n_we, n_oe, n_dq, at, rwe, rd, ben, rdy, tmo);
        checks++;
        if ({tmo, n_ce, n_we, n_oe, n_dq, at} !== {1'b0, 32'(WC+2), 32'(WC), 32'd0, 32'(WC+2), 32'(WC+2)}) begin
            errors++;
            $display("FAIL write_phases: tmo=%0d ce=%0d we=%0d oe=%0d dq=%0d rsp_at=%0d want 0 %0d %0d 0 %0d %0d",
                     tmo, n_ce, n_we, n_oe, n_dq, at, WC+2, WC, WC+2, WC+2);
        end
        checks++;
        if ({rwe, ben, rdy, rd} !== {1'b1, 4'b0000, 1'b1, exp_rd}) begin
            errors++;
            $display("FAIL write_rsp: rsp_we=%b be_n=%b rdy=%b rdata=%h want 1 0000 1 %h", rwe, ben, rdy, rd, exp_rd);
        end
        checks++;
        if (sram_mem[20'h00012] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL write_stored: got %h want deadbeef", sram_mem[20'h00012]);
        end
    endtask

    task automatic test_readback;
        int n_ce, n_we, n_oe, n_dq, at; logic rwe, rdy; logic [DW-1:0] rd, exp_rd; logic [BW-1:0] ben; bit tmo;
        exp_rd = model_cmd(1'b0, 20'h00012, '0, '0);
        run_cmd(1'b0, 20'h00012, 32'h12345678, 4'h5, n_ce, n_we, n_oe, n_dq, at, rwe, rd, ben, rdy, tmo);
        checks++;
        if ({tmo, n_oe, n_we, n_dq, at, rwe, ben} !== {1'b0, 32'(WC), 32'd0, 32'd0, 32'(WC+2), 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL read_phases: tmo=%0d oe=%0d we=%0d dq=%0d rsp_at=%0d rsp_we=%b be_n=%b", tmo, n_oe,
                     n_we, n_dq, at, rwe, ben);
        end
        checks++;
        if (rd !== 32'hDEADBEEF || exp_rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL readback: got %h want deadbeef", rd);
        end
    endtask

    task automatic test_byte_write;
        int n_ce, n_we, n_oe, n_dq, at; logic rwe, rdy; logic [DW-1:0] rd, unused; logic [BW-1:0] ben; bit tmo;
        unused = model_cmd(1'b1, 20'h00100, 32'hFFFFFFFF, 4'hF);
        run_cmd(1'b1, 20'h00100, 32'hFFFFFFFF, 4'hF, n_ce, n_we, n_oe, n_dq, at, rwe, rd, ben, rdy, tmo);
        unused = model_cmd(1'b1, 20'h00100, 32'h0000AB00, 4'b0010);
        run_cmd(1'b1, 20'h00100, 32'h0000AB00, 4'b0010, n_ce, n_we, n_oe, n_dq, at, rwe, rd, ben, rdy, tmo);
        checks++;
        if (ben !== 4'b1101 || tmo) begin
            errors++; $display("FAIL byte_be_n: got %b want 1101", ben);
        end
        unused = model_cmd(1'b0, 20'h00100, '0, '0);
        run_cmd(1'b0, 20'h00100, '0, '0, n_ce, n_we, n_oe, n_dq, at, rwe, rd, ben, rdy, tmo);
        checks++;
        if (rd !== 32'hFFFFABFF) begin
            errors++; $display("FAIL byte_readback: got %h want ffffabff", rd);
        end
    endtask

    task automatic test_back_to_back;
        localparam int N = 8;
        int idx, n_rsp, last_acc, c;
        logic [DW-1:0] unused;
        idx = 0; n_rsp = 0; last_acc = -1; c = 0;
        @(negedge clk);
        bus.cmd_addr = 20'hFFFFF; bus.cmd_wdata = 32'h5A5A5A5A; bus.cmd_be = 4'hF;
        bus.cmd_valid = 1'b1;
        while (n_rsp < N && c < N * (WC + 3) + 20) begin
            if (bus.rsp_valid) begin
                n_rsp++;
                if (!bus.rsp_we) begin
                    checks++;
                    if (bus.rsp_rdata !== 32'h5A5A5A5A) begin
                        errors++; $display("FAIL b2b_rdata: got %h want 5a5a5a5a", bus.rsp_rdata);
                    end
                end
            end
            bus.cmd_we = (idx % 2 == 0);
            if (idx < N && bus.cmd_ready) begin
                unused = model_cmd(bus.cmd_we, bus.cmd_addr, bus.cmd_wdata, bus.cmd_be);
                if (last_acc >= 0) begin
                    checks++;
                    if (c - last_acc != WC + 3) begin
                        errors++; $display("FAIL b2b_spacing: got %0d want %0d", c - last_acc, WC + 3);
                    end
                end
                last_acc = c;
                idx++;
                if (idx == N) begin
                    @(posedge clk);
                    #1 bus.cmd_valid = 1'b0;
                end
            end
            @(negedge clk);
            c++;
        end
        bus.cmd_valid = 1'b0;
        checks++;
        if (n_rsp != N) begin
            errors++; $display("FAIL b2b_count: got %0d want %0d", n_rsp, N);
        end
    endtask

    task automatic test_reset_mid_write;
        int w, n_rv; logic rdy1;
        int n_ce, n_we, n_oe, n_dq, at; logic rwe, rdy; logic [DW-1:0] rd, exp_rd; logic [BW-1:0] ben; bit tmo;
        @(negedge clk);
        bus.cmd_we = 1'b1; bus.cmd_addr = 20'h00200; bus.cmd_wdata = 32'h11111111; bus.cmd_be = 4'hF;
        bus.cmd_valid = 1'b1;
        w = 0;
        while (!bus.cmd_ready && w < 20) begin @(negedge clk); w++; end
        @(posedge clk);
        @(negedge clk); bus.cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.sram_we_n, bus.sram_dq_oe} !== 2'b01) begin
            errors++; $display("FAIL abort_pre: we_n/dq_oe=%b want 01", {bus.sram_we_n, bus.sram_dq_oe});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.sram_ce_n, bus.sram_we_n, bus.sram_oe_n, bus.sram_dq_oe} !== 4'b1110) begin
            errors++;
            $display("FAIL abort_async: ce/we/oe/dq_oe=%b want 1110",
                     {bus.sram_ce_n, bus.sram_we_n, bus.sram_oe_n, bus.sram_dq_oe});
        end
        @(negedge clk);
        rst = 1'b0;
        #1 rdy1 = bus.cmd_ready;
        n_rv = 0;
        for (int i = 0; i < WC + 3; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) n_rv++;
        end
        checks++;
        if (rdy1 !== 1'b1 || n_rv != 0) begin
            errors++; $display("FAIL abort_after: ready=%b rsp_valid_pulses=%0d want 1 0", rdy1, n_rv);
        end
        exp_rd = model_cmd(1'b0, 20'h00100, '0, '0);
        run_cmd(1'b0, 20'h00100, '0, '0, n_ce, n_we, n_oe, n_dq, at, rwe, rd, ben, rdy, tmo);
        checks++;
        if (tmo || at != WC + 2 || rd !== exp_rd) begin
            errors++; $display("FAIL abort_next_cmd: rsp_at=%0d rdata=%h want %0d %h", at, rd, WC + 2, exp_rd);
        end
    endtask

    task automatic test_random;
        logic [AW-1:0] pool [4];
        int n_ce, n_we, n_oe, n_dq, at; logic rwe, rdy; logic [DW-1:0] rd, exp_rd, d; logic [BW-1:0] ben, be;
        logic we; logic [AW-1:0] a; bit tmo;
        for (int i = 0; i < 4; i++) pool[i] = AW'($urandom);
        pool[3] = 20'hFFFFF;
        for (int i = 0; i < 28; i++) begin
            we = (i < 4) ? 1'b1 : 1'($urandom);
            a = (i < 4) ? pool[i] : pool[$urandom_range(0, 3)];
            d = $urandom;
            be = (i < 4) ? 4'hF : BW'($urandom);
            exp_rd = model_cmd(we, a, d, be);
            run_cmd(we, a, d, be, n_ce, n_we, n_oe, n_dq, at, rwe, rd, ben, rdy, tmo);
            checks++;
            if (tmo || at != WC + 2 || rwe !== we || rd !== exp_rd || rdy !== 1'b1) begin
                errors++;
                $display("FAIL random_cmd%0d: we=%b rsp_at=%0d rsp_we=%b rdata=%h rdy=%b want rsp_at=%0d rdata=%h",
                         i, we, at, rwe, rd, rdy, WC + 2, exp_rd);
            end
            checks++;
            if (we && (ben !== ~be || n_dq != WC + 2) || !we && (ben !== '0 || n_dq != 0)) begin
                errors++; $display("FAIL random_pads%0d: be_n=%b dq_cyc=%0d for we=%b be=%b", i, ben, n_dq, we, be);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0; bus.cmd_be = '0;
        test_reset();
        test_single_write();
        test_readback();
        test_byte_write();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
